argo_chan_arbiter: RTL and testbench
====================================

# argo_chan_arbiter

Multi-writer front end for one `argo_fifo` channel instance. It shares the FIFO write port between `NUM_WRITERS` sender processes using round-robin arbitration, and drives the FIFO's `wr_en`/`wr_data` from registers. It tracks FIFO space with its own credit counter, so no write is ever issued into a full FIFO despite the FIFO's registered `full` flag. It sits between the compiled sender state machines and the channel FIFO; the reader side connects to the FIFO directly, and its `rd_en` is also tapped into this block.

## Interface
Parameters:
- `NUM_WRITERS`, 4: number of requesters, 2..16.
- `ID_WIDTH`, 2: width of a writer index; must be ≥ ceil(log2(NUM_WRITERS)).
- `DATA_WIDTH`, 32: channel element width; must match the FIFO.
- `ADDR_WIDTH`, 3: FIFO address width; must match the FIFO.
- `DEPTH`, 1<<ADDR_WIDTH: FIFO depth. Usable capacity is DEPTH-1, because the FIFO asserts `full` at DEPTH-1 items.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_req`  in  NUM_WRITERS: per-writer request level.
- `wr_data`  in  NUM_WRITERS*DATA_WIDTH: flattened data; writer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_ack`  out  NUM_WRITERS: one-cycle accept pulse, one-hot or zero.
- `fifo_wr_en`  out  1: drives the FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_WIDTH: drives the FIFO `wr_data`.
- `fifo_full`  in  1: the FIFO `full` flag.
- `fifo_rd_en`  in  1: copy of the reader's `rd_en` to the FIFO.
- `grant_id`  out  ID_WIDTH: index of the writer accepted; valid while `fifo_wr_en`=1.
- `credits`  out  ADDR_WIDTH+1: free slots as seen by the arbiter.

## Operation
- State:
  - `rr_ptr` (ID_WIDTH bits): highest-priority writer index.
  - `credits`: free-slot counter.
  - Registered outputs: `wr_ack`, `fifo_wr_en`, `fifo_wr_data`, `grant_id`.
- Eligibility: writer i is eligible when `wr_req[i]`=1 and `wr_ack[i]`=0. The ack mask prevents a double accept while a writer drops its request.
- Issue condition: at least one eligible writer, `credits` ≠ 0, and `fifo_full`=0.
- Winner: the first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_WRITERS.
- On issue, at the next edge:
  - `fifo_wr_en`=1.
  - `fifo_wr_data` = winner's data.
  - `grant_id` = winner.
  - `wr_ack[winner]`=1.
  - `rr_ptr` = (winner+1) mod NUM_WRITERS. Index NUM_WRITERS-1 wraps to 0; it is not computed as a power of two.
- No issue: `fifo_wr_en`=0, `wr_ack`=0, and `rr_ptr` holds. `fifo_wr_data` and `grant_id` hold their last values.
- Credits, per edge:
  - issue only: `credits` − 1.
  - `fifo_rd_en` only: `credits` + 1, saturating at DEPTH-1.
  - both, or neither: unchanged.
- `fifo_rd_en` while `credits`=DEPTH-1 (read of an empty FIFO) leaves `credits` at DEPTH-1.
- Writer protocol:
  - Hold `wr_req` and `wr_data` stable until `wr_ack` is sampled high.
  - Drop `wr_req` at the edge where `wr_ack` is sampled, or raise it again for the next element.
  - Data is captured at the issue edge; later changes are ignored.

## Timing
- Reset: `wr_ack`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `grant_id`=0, `rr_ptr`=0, `credits`=DEPTH-1.
- Reset mid-operation:
  - Any pending grant is discarded and no write is issued on the reset edge.
  - The FIFO must be reset in the same cycle.
- Latency: request sampled at edge t → `fifo_wr_en` and `wr_ack` high during cycle t..t+1. The FIFO commits the write at edge t+1.
- Throughput:
  - One write per cycle across different writers.
  - A single writer holding `wr_req` high is accepted at most every 2 cycles, because of the ack mask.
- `fifo_full` is a secondary guard only. `credits` alone guarantees no overflow, since `credits` reaches 0 no later than `full` rises.
- `wr_ack` is never high for more than one consecutive cycle per writer.

## Test plan
- Reset behaviour: assert `rst` with all `wr_req`=1 → all outputs stay at their reset values and `credits`=7 (DEPTH=8).
- Round-robin order: `wr_req`=4'b1111 held, each writer sending `data` = 0x100+i, reader popping every cycle → grant order 0,1,2,3,0,…; each `wr_ack[i]` is a single-cycle pulse; FIFO output reads 0x100, 0x101, 0x102, 0x103.
- Fill to capacity: writer 2 alone, no reads → exactly 7 accepts and `credits`=0, then stall. One `fifo_rd_en` → 8th accept exactly 1 cycle later, `credits` back to 0.
- Simultaneous read and write at `credits`=3 → `credits` stays 3. Spurious `fifo_rd_en` at `credits`=7 → `credits` stays 7.
- Wrap and skip: `rr_ptr`=3 with only writers 1 and 3 requesting → grant 3, then 1, then 3; `rr_ptr` goes 3→0→2→0.
- Reset mid-stream: `rst` asserted the edge after a grant to writer 1 → `credits`=7, `rr_ptr`=0, no further `fifo_wr_en` until `rst` is released. The first post-reset grant goes to the lowest requesting index.

Source files
------------

// File: rtl/argo_chan_arbiter_if.sv
// rtl/argo_chan_arbiter_if.sv - writer/FIFO-side signal bundle for the channel arbiter
interface argo_chan_arbiter_if #(
    parameter int NUM_WRITERS = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3
);
    logic [NUM_WRITERS-1:0]            wr_req;
    logic [NUM_WRITERS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WRITERS-1:0]            wr_ack;
    logic                              fifo_wr_en;
    logic [DATA_WIDTH-1:0]             fifo_wr_data;
    logic                              fifo_full;
    logic                              fifo_rd_en;
    logic [ID_WIDTH-1:0]               grant_id;
    logic [ADDR_WIDTH:0]               credits;

    modport master (
        output wr_req, wr_data, fifo_full, fifo_rd_en,
        input  wr_ack, fifo_wr_en, fifo_wr_data, grant_id, credits
    );

    modport slave (
        input  wr_req, wr_data, fifo_full, fifo_rd_en,
        output wr_ack, fifo_wr_en, fifo_wr_data, grant_id, credits
    );
endinterface

// File: rtl/argo_chan_arbiter.sv
// rtl/argo_chan_arbiter.sv - round-robin multi-writer front end with credit tracking for one FIFO channel
module argo_chan_arbiter #(
    parameter int NUM_WRITERS = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int DEPTH       = 1 << ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    argo_chan_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]  CRED_MAX = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]  CRED_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_WRITERS - 1);
    localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);

    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ADDR_WIDTH:0]    credits_q;
    logic [NUM_WRITERS-1:0] wr_ack_q;
    logic                   wr_en_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic [ID_WIDTH-1:0]    grant_q;

    logic [NUM_WRITERS-1:0] eligible;
    logic                   found;
    logic [ID_WIDTH-1:0]    winner;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   issue;
    int                     scan_idx;

    // The ack mask keeps a writer that is still dropping its request from being accepted twice.
    always_comb begin
        eligible = bus.wr_req & ~wr_ack_q;
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_WRITERS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_WRITERS) scan_idx = scan_idx - NUM_WRITERS;
            if (!found && eligible[ID_WIDTH'(scan_idx)]) begin
                found    = 1'b1;
                winner   = ID_WIDTH'(scan_idx);
                win_data = bus.wr_data[scan_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        issue = found && (credits_q != '0) && !bus.fifo_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            credits_q <= CRED_MAX;
            wr_ack_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            grant_q   <= '0;
        end else begin
            wr_en_q  <= issue;
            wr_ack_q <= issue ? (NUM_WRITERS'(1) << winner) : '0;
            if (issue) begin
                wr_data_q <= win_data;
                grant_q   <= winner;
                rr_ptr    <= (winner == LAST_ID) ? '0 : winner + ID_ONE;
            end
            // A read of an empty FIFO must not push credits past the usable capacity.
            if (issue && !bus.fifo_rd_en)
                credits_q <= credits_q - CRED_ONE;
            else if (!issue && bus.fifo_rd_en && credits_q != CRED_MAX)
                credits_q <= credits_q + CRED_ONE;
        end
    end

    assign bus.wr_ack       = wr_ack_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.grant_id     = grant_q;
    assign bus.credits      = credits_q;
endmodule

// File: tb/tb_argo_chan_arbiter.sv
// tb/tb_argo_chan_arbiter.sv - self-checking bench for argo_chan_arbiter with a FIFO and arbitration reference model
module tb_argo_chan_arbiter;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int DW   = 32;
    localparam int AW   = 3;
    localparam int CMAX = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    argo_chan_arbiter_if #(.NUM_WRITERS(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    argo_chan_arbiter #(.NUM_WRITERS(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int             m_rr;
    int             m_cred;
    logic [N-1:0]   m_ack;
    logic           m_en;
    logic [DW-1:0]  m_data;
    int             m_gid;

    logic [DW-1:0]  fq[$];
    logic [DW-1:0]  popped[$];

    task automatic set_data(input int i, input logic [DW-1:0] v);
        bus.wr_data[i*DW +: DW] = v;
    endtask

    task automatic model_edge();
        int  win;
        int  idx;
        bit  iss;
        win = -1;
        if (rst) begin
            m_rr = 0; m_cred = CMAX; m_ack = '0; m_en = 1'b0; m_data = '0; m_gid = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && bus.wr_req[idx] && !m_ack[idx]) win = idx;
        end
        iss = (win >= 0) && (m_cred > 0) && !bus.fifo_full;
        m_cred = m_cred - (iss ? 1 : 0) + (bus.fifo_rd_en ? 1 : 0);
        if (m_cred > CMAX) m_cred = CMAX;
        m_ack = '0;
        m_en  = iss;
        if (iss) begin
            m_ack[win] = 1'b1;
            m_data     = bus.wr_data[win*DW +: DW];
            m_gid      = win;
            m_rr       = (win + 1) % N;
        end
    endtask

    task automatic tick();
        logic          en_b;
        logic          rd_b;
        logic [DW-1:0] d_b;
        model_edge();
        en_b = bus.fifo_wr_en;
        d_b  = bus.fifo_wr_data;
        rd_b = bus.fifo_rd_en;
        @(posedge clk);
        if (rst) fq.delete();
        else begin
            if (rd_b && fq.size() > 0) popped.push_back(fq.pop_front());
            if (en_b) fq.push_back(d_b);
        end
        #1;
        bus.fifo_full = (fq.size() >= CMAX);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_req = '0;
        bus.fifo_rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_req = '1;
        for (int i = 0; i < N; i++) set_data(i, $urandom);
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (bus.wr_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.wr_ack); end
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
        n_cmp++; if (bus.fifo_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", bus.fifo_wr_data); end
        n_cmp++; if (bus.grant_id !== '0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        n_cmp++; if (bus.credits !== 4'd7) begin n_fail++; $display("FAIL reset_credits: got %0d want 7", bus.credits); end
        rst = 1'b0;
        bus.wr_req = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev;
        logic [N-1:0] e_ack;
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 32'h100 + i);
        bus.wr_req = '1;
        bus.fifo_rd_en = 1'b1;
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            e_ack = N'(1) << (k % N);
            n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en[%0d]: got %b want 1", k, bus.fifo_wr_en); end
            n_cmp++; if (bus.grant_id !== IDW'(k % N)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, bus.grant_id, k % N); end
            n_cmp++; if (bus.wr_ack !== e_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.wr_ack, e_ack); end
            n_cmp++; if ((bus.wr_ack & prev) !== '0) begin n_fail++; $display("FAIL rr_ack_pulse[%0d]: got %b prev %b want no overlap", k, bus.wr_ack, prev); end
            n_cmp++; if (bus.fifo_wr_data !== 32'h100 + (k % N)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus.fifo_wr_data, 32'h100 + (k % N)); end
            prev = bus.wr_ack;
        end
        bus.fifo_rd_en = 1'b0;
        bus.wr_req = '0;
        n_cmp++;
        if (popped.size() < 4) begin
            n_fail++; $display("FAIL rr_pop_count: got %0d want >=4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (popped[i] !== 32'h100 + i) begin n_fail++; $display("FAIL rr_pop[%0d]: got %h want %h", i, popped[i], 32'h100 + i); end
            end
        end
    endtask

    task automatic test_fill();
        int acks;
        do_reset();
        acks = 0;
        bus.wr_req = 4'b0100;
        set_data(2, $urandom);
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++; if (bus.wr_ack !== m_ack) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b want %b", k, bus.wr_ack, m_ack); end
            n_cmp++; if (bus.credits !== (AW+1)'(m_cred)) begin n_fail++; $display("FAIL fill_credits[%0d]: got %0d want %0d", k, bus.credits, m_cred); end
            if (m_en) begin
                n_cmp++; if (bus.fifo_wr_data !== m_data) begin n_fail++; $display("FAIL fill_data[%0d]: got %h want %h", k, bus.fifo_wr_data, m_data); end
            end
            if (bus.wr_ack[2]) begin acks++; set_data(2, $urandom); end
        end
        n_cmp++; if (acks != 7) begin n_fail++; $display("FAIL fill_accepts: got %0d want 7", acks); end
        n_cmp++; if (bus.credits !== 4'd0) begin n_fail++; $display("FAIL fill_credits_zero: got %0d want 0", bus.credits); end
        bus.fifo_rd_en = 1'b1;
        tick();
        bus.fifo_rd_en = 1'b0;
        n_cmp++; if (bus.credits !== 4'd1) begin n_fail++; $display("FAIL fill_after_read_credits: got %0d want 1", bus.credits); end
        n_cmp++; if (bus.wr_ack !== 4'b0000) begin n_fail++; $display("FAIL fill_after_read_ack: got %b want 0000", bus.wr_ack); end
        tick();
        n_cmp++; if (bus.wr_ack !== 4'b0100) begin n_fail++; $display("FAIL fill_eighth_ack: got %b want 0100", bus.wr_ack); end
        n_cmp++; if (bus.credits !== 4'd0) begin n_fail++; $display("FAIL fill_eighth_credits: got %0d want 0", bus.credits); end
        bus.wr_req = '0;
    endtask

    task automatic test_simul_rw();
        do_reset();
        bus.wr_req = 4'b0001;
        set_data(0, $urandom);
        for (int k = 0; k < 40 && m_cred > 3; k++) begin
            tick();
            if (bus.wr_ack[0]) set_data(0, $urandom);
        end
        bus.wr_req = '0;
        tick();
        n_cmp++; if (bus.credits !== 4'd3) begin n_fail++; $display("FAIL simul_setup_credits: got %0d want 3", bus.credits); end
        bus.wr_req = 4'b0001;
        bus.fifo_rd_en = 1'b1;
        tick();
        bus.fifo_rd_en = 1'b0;
        bus.wr_req = '0;
        n_cmp++; if (bus.credits !== 4'd3) begin n_fail++; $display("FAIL simul_credits: got %0d want 3", bus.credits); end
        n_cmp++; if (bus.wr_ack !== 4'b0001) begin n_fail++; $display("FAIL simul_ack: got %b want 0001", bus.wr_ack); end
        do_reset();
        bus.fifo_rd_en = 1'b1;
        tick();
        bus.fifo_rd_en = 1'b0;
        n_cmp++; if (bus.credits !== 4'd7) begin n_fail++; $display("FAIL spurious_read_credits: got %0d want 7", bus.credits); end
        n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL spurious_read_wr_en: got %b want 0", bus.fifo_wr_en); end
    endtask

    task automatic test_wrap_skip();
        int exp_g[3];
        exp_g = '{3, 1, 3};
        do_reset();
        bus.wr_req = 4'b0100;
        tick();
        n_cmp++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL wrap_setup_grant: got %0d want 2", bus.grant_id); end
        bus.wr_req = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL wrap_wr_en[%0d]: got %b want 1", j, bus.fifo_wr_en); end
            n_cmp++; if (bus.grant_id !== IDW'(exp_g[j])) begin n_fail++; $display("FAIL wrap_grant[%0d]: got %0d want %0d", j, bus.grant_id, exp_g[j]); end
        end
        bus.wr_req = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] req;
        int           low;
        do_reset();
        bus.wr_req = 4'b0010;
        set_data(1, $urandom);
        tick();
        n_cmp++; if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL midrst_pre_grant: got %0d want 1", bus.grant_id); end
        rst = 1'b1;
        bus.wr_req = '1;
        for (int j = 0; j < 2; j++) begin
            tick();
            n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en[%0d]: got %b want 0", j, bus.fifo_wr_en); end
            n_cmp++; if (bus.wr_ack !== '0) begin n_fail++; $display("FAIL midrst_ack[%0d]: got %b want 0", j, bus.wr_ack); end
            n_cmp++; if (bus.credits !== 4'd7) begin n_fail++; $display("FAIL midrst_credits[%0d]: got %0d want 7", j, bus.credits); end
        end
        rst = 1'b0;
        req = N'($urandom_range(1, (1 << N) - 1));
        bus.wr_req = req;
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (req[i]) low = i;
        tick();
        n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_post_wr_en: got %b want 1", bus.fifo_wr_en); end
        n_cmp++; if (bus.grant_id !== IDW'(low)) begin n_fail++; $display("FAIL midrst_post_grant: got %0d want %0d (req %b)", bus.grant_id, low, req); end
        bus.wr_req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.fifo_rd_en = (fq.size() > 0) && ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++; if (bus.fifo_wr_en !== m_en) begin n_fail++; $display("FAIL rand_wr_en[%0d]: got %b want %b", cyc, bus.fifo_wr_en, m_en); end
            n_cmp++; if (bus.wr_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b want %b", cyc, bus.wr_ack, m_ack); end
            n_cmp++; if (bus.credits !== (AW+1)'(m_cred)) begin n_fail++; $display("FAIL rand_credits[%0d]: got %0d want %0d", cyc, bus.credits, m_cred); end
            if (m_en) begin
                n_cmp++; if (bus.grant_id !== IDW'(m_gid)) begin n_fail++; $display("FAIL rand_grant[%0d]: got %0d want %0d", cyc, bus.grant_id, m_gid); end
                n_cmp++; if (bus.fifo_wr_data !== m_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", cyc, bus.fifo_wr_data, m_data); end
            end
            n_cmp++; if (fq.size() > CMAX) begin n_fail++; $display("FAIL rand_overflow[%0d]: got %0d items want <=%0d", cyc, fq.size(), CMAX); end
            for (int i = 0; i < N; i++) begin
                if (bus.wr_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) set_data(i, $urandom);
                    else bus.wr_req[i] = 1'b0;
                end else if (!bus.wr_req[i] && $urandom_range(0, 2) == 0) begin
                    bus.wr_req[i] = 1'b1;
                    set_data(i, $urandom);
                end
            end
        end
        bus.wr_req = '0;
        bus.fifo_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_req = '0;
        bus.wr_data = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_rd_en = 1'b0;
        test_reset();
        test_round_robin();
        test_fill();
        test_simul_rw();
        test_wrap_skip();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
